// File: rtl/stepper_nphase_ctrl_if.sv
// Command, comparator and drive signals of the N-phase stepper controller.
// The master side drives the motion pins; the slave side is the controller.
interface stepper_nphase_ctrl_if #(
    parameter int unsigned PHASES = 5,
    parameter int unsigned POS_W  = 16
);
    logic                  ena;
    logic                  pul;
    logic                  dir;
    logic                  mod;
    logic [PHASES-1:0]     cmps;
    logic [2*PHASES-1:0]   outs;
    logic                  hfc;
    logic [POS_W-1:0]      pos;
    logic                  fault;

    modport master (
        output ena, pul, dir, mod, cmps,
        input  outs, hfc, pos, fault
    );

    modport slave (
        input  ena, pul, dir, mod, cmps,
        output outs, hfc, pos, fault
    );
endinterface

// File: rtl/stepper_nphase_ctrl.sv
// N-phase stepper controller: step ring, per-coil chopping latch, hold timer, position.
// Define STEP_RATE_FAULT_EN to drop steps closer than MIN_GAP cycles and flag fault.
module stepper_nphase_ctrl #(
    parameter int unsigned PHASES       = 5,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned HOLD_PERIODS = 16384,
    parameter int unsigned POS_W        = 16,
    parameter int unsigned MIN_GAP      = 64
) (
    input  logic                  osc,
    input  logic                  rst,
    stepper_nphase_ctrl_if.slave  bus
);
    localparam int unsigned L      = 4 * PHASES;
    localparam int unsigned IDLE_W = $clog2(HOLD_PERIODS + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(HOLD_PERIODS);
    localparam logic [L-1:0] RING_RST = {{(2*PHASES-1){1'b1}}, {(2*PHASES+1){1'b0}}};

    logic [L-1:0]          ring_q, ring_d;
    logic                  half_odd_q, half_odd_d;
    logic [2*PHASES-1:0]   outs_q, outs_d;
    logic                  hfc_q, hfc_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  fault_q, fault_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [2:0]            pul_sync_q, pul_sync_d;
    logic [PHASES-1:0]     cmps_s1_q, cmps_s2_q;

    logic                  step_ev, step_ok, gap_ok, period_start, shift2;
    logic [POS_W-1:0]      delta;
    logic [2*PHASES-1:0]   taps;

`ifdef STEP_RATE_FAULT_EN
    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);
    logic [GAP_W-1:0] gap_q, gap_d;
`else
    logic unused_min_gap;
    assign unused_min_gap = |MIN_GAP;
`endif

    always_comb begin
        // pul_sync_q[1] is the synchronized level, [2] its previous value
        step_ev      = pul_sync_q[1] & ~pul_sync_q[2];
        period_start = bus.ena && (pwm_q == '0);
        pul_sync_d   = {pul_sync_q[1:0], bus.pul};

`ifdef STEP_RATE_FAULT_EN
        gap_ok  = (gap_q >= GAP_MAX);
        step_ok = step_ev & bus.ena & gap_ok;
        gap_d   = gap_q;
        if (step_ok) begin
            gap_d = GAP_W'(1);
        end else if (gap_q < GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
        fault_d = fault_q;
        if (!bus.ena) begin
            fault_d = 1'b0;
        end else if (step_ev && !gap_ok) begin
            fault_d = 1'b1;
        end
`else
        gap_ok  = 1'b1;
        step_ok = step_ev & bus.ena & gap_ok;
        fault_d = 1'b0;
`endif

        // Full step from an odd half position only realigns by one bit
        shift2     = bus.mod & ~half_odd_q;
        delta      = shift2 ? POS_W'(2) : POS_W'(1);
        ring_d     = ring_q;
        pos_d      = pos_q;
        half_odd_d = half_odd_q;
        if (step_ok) begin
            if (!bus.dir) begin
                ring_d = shift2 ? {ring_q[L-3:0], ring_q[L-1:L-2]} : {ring_q[L-2:0], ring_q[L-1]};
                pos_d  = pos_q + delta;
            end else begin
                ring_d = shift2 ? {ring_q[1:0], ring_q[L-1:2]} : {ring_q[0], ring_q[L-1:1]};
                pos_d  = pos_q - delta;
            end
            half_odd_d = bus.mod ? 1'b0 : ~half_odd_q;
        end

        for (int k = 0; k < int'(PHASES); k++) begin
            taps[2*k]   = ring_q[(4*k) % L];
            taps[2*k+1] = ring_q[(4*k + 2*PHASES) % L];
        end

        outs_d = outs_q;
        if (!bus.ena) begin
            outs_d = '0;
        end else begin
            for (int k = 0; k < int'(PHASES); k++) begin
                if (period_start) begin
                    outs_d[2*k +: 2] = cmps_s2_q[k] ? taps[2*k +: 2] : 2'b00;
                end else if (!cmps_s2_q[k]) begin
                    outs_d[2*k +: 2] = 2'b00;
                end
            end
        end

        pwm_d  = bus.ena ? pwm_q + PWM_BITS'(1) : '0;
        idle_d = idle_q;
        hfc_d  = hfc_q;
        if (!bus.ena || step_ok) begin
            idle_d = '0;
            hfc_d  = 1'b1;
        end else if (period_start) begin
            if (idle_q < IDLE_MAX) begin
                idle_d = idle_q + IDLE_W'(1);
            end
            if (idle_d >= IDLE_MAX) begin
                hfc_d = 1'b0;
            end
        end
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            ring_q     <= RING_RST;
            half_odd_q <= 1'b0;
            outs_q     <= '0;
            hfc_q      <= 1'b1;
            pos_q      <= '0;
            fault_q    <= 1'b0;
            pwm_q      <= '0;
            idle_q     <= '0;
            pul_sync_q <= '0;
            cmps_s1_q  <= '0;
            cmps_s2_q  <= '0;
`ifdef STEP_RATE_FAULT_EN
            gap_q      <= GAP_MAX;
`endif
        end else begin
            ring_q     <= ring_d;
            half_odd_q <= half_odd_d;
            outs_q     <= outs_d;
            hfc_q      <= hfc_d;
            pos_q      <= pos_d;
            fault_q    <= fault_d;
            pwm_q      <= pwm_d;
            idle_q     <= idle_d;
            pul_sync_q <= pul_sync_d;
            cmps_s1_q  <= bus.cmps;
            cmps_s2_q  <= cmps_s1_q;
`ifdef STEP_RATE_FAULT_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign bus.outs  = outs_q;
    assign bus.hfc   = hfc_q;
    assign bus.pos   = pos_q;
    assign bus.fault = fault_q;
endmodule

// File: tb/tb_stepper_nphase_ctrl.sv
// Directed bench for stepper_nphase_ctrl: PHASES=5, PWM_BITS=4, HOLD_PERIODS=3.
// Step-table vectors plus hand-written reset, chopping, enable and step-rate sequences.
module tb_stepper_nphase_ctrl;
    localparam int unsigned PHASES = 5;
    localparam int unsigned POS_W  = 16;
    localparam int unsigned PERIOD = 16;

    logic osc = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ena_cyc = 0;
    int   passed = 0;
    int   total = 0;

    stepper_nphase_ctrl_if #(.PHASES(PHASES), .POS_W(POS_W)) bus ();

    stepper_nphase_ctrl #(
        .PHASES      (PHASES),
        .PWM_BITS    (4),
        .HOLD_PERIODS(3),
        .POS_W       (POS_W),
        .MIN_GAP     (64)
    ) dut (
        .osc(osc),
        .rst(rst),
        .bus(bus)
    );

    always #5 osc = ~osc;
    always @(posedge osc) cyc <= cyc + 1;

    typedef struct {
        logic        dir;
        logic        mod;
        int          n_steps;
        logic [15:0] exp_pos;
        logic [9:0]  exp_outs;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge osc);
    endtask

    function automatic int phase();
        return (cyc - ena_cyc) % PERIOD;
    endfunction

    task automatic wait_phase(input int p);
        tick(1);
        for (int i = 0; i < int'(PERIOD); i++) begin
            if (phase() == p) break;
            tick(1);
        end
    endtask

    // One pul pulse, then enough idle time for several period starts
    task automatic pulse();
        bus.pul = 1'b1;
        tick(3);
        bus.pul = 1'b0;
        tick(67);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0,  0, 16'd0,      10'h168};
        vecs[1] = '{1'b0, 1'b0, 20, 16'd20,     10'h168};
        vecs[2] = '{1'b1, 1'b0, 20, 16'd0,      10'h168};
        vecs[3] = '{1'b0, 1'b0,  1, 16'd1,      10'h169};
        vecs[4] = '{1'b0, 1'b1,  1, 16'd2,      10'h129};
        vecs[5] = '{1'b0, 1'b1,  1, 16'd4,      10'h1A1};
        vecs[6] = '{1'b1, 1'b1,  2, 16'd0,      10'h168};
        vecs[7] = '{1'b1, 1'b1,  1, 16'hFFFE,   10'h14A};
        vecs[8] = '{1'b0, 1'b1,  1, 16'd0,      10'h168};

        bus.ena  = 1'b0;
        bus.pul  = 1'b0;
        bus.dir  = 1'b0;
        bus.mod  = 1'b0;
        bus.cmps = '1;
        tick(3);
        chk("rst_outs", 32'(bus.outs), 32'h0);
        chk("rst_pos", 32'(bus.pos), 32'h0);
        chk("rst_hfc", 32'(bus.hfc), 32'h1);
        chk("rst_fault", 32'(bus.fault), 32'h0);

        rst = 1'b0;
        tick(3);
        chk("pre_ena_outs", 32'(bus.outs), 32'h0);
        bus.ena = 1'b1;
        ena_cyc = cyc + 1;
        tick(1);
        chk("first_period_outs", 32'(bus.outs), 32'h168);
        chk("first_period_hfc", 32'(bus.hfc), 32'h1);
        tick(18);
        chk("hold_two_periods", 32'(bus.hfc), 32'h1);
        tick(30);
        chk("hold_three_periods", 32'(bus.hfc), 32'h0);

        for (int v = 0; v < 9; v++) begin
            bus.dir = vecs[v].dir;
            bus.mod = vecs[v].mod;
            if (vecs[v].n_steps == 0) tick(70);
            for (int s = 0; s < vecs[v].n_steps; s++) pulse();
            chk($sformatf("vec%0d_pos", v), 32'(bus.pos), 32'(vecs[v].exp_pos));
            chk($sformatf("vec%0d_outs", v), 32'(bus.outs), 32'(vecs[v].exp_outs));
            chk($sformatf("vec%0d_hfc", v), 32'(bus.hfc), 32'h0);
            chk($sformatf("vec%0d_fault", v), 32'(bus.fault), 32'h0);
        end

        // Overcurrent on coil 2 mid-period
        wait_phase(5);
        bus.cmps[2] = 1'b0;
        tick(2);
        chk("cmps_sync_delay", 32'(bus.outs), 32'h168);
        tick(1);
        chk("cmps_chop", 32'(bus.outs), 32'h148);
        wait_phase(1);
        chk("cmps_low_at_start", 32'(bus.outs), 32'h148);
        wait_phase(5);
        bus.cmps[2] = 1'b1;
        tick(4);
        chk("cmps_release_hold", 32'(bus.outs), 32'h148);
        wait_phase(0);
        chk("cmps_reload", 32'(bus.outs), 32'h168);

        // Enable drop mid-run
        wait_phase(7);
        bus.dir = 1'b0;
        bus.mod = 1'b0;
        bus.ena = 1'b0;
        tick(1);
        chk("ena_off_outs", 32'(bus.outs), 32'h0);
        chk("ena_off_hfc", 32'(bus.hfc), 32'h1);
        pulse();
        chk("ena_off_pos", 32'(bus.pos), 32'h0);
        chk("ena_off_outs_hold", 32'(bus.outs), 32'h0);
        bus.ena = 1'b1;
        ena_cyc = cyc + 1;
        tick(1);
        chk("ena_resume_outs", 32'(bus.outs), 32'h168);
        pulse();
        chk("resume_step_pos", 32'(bus.pos), 32'h1);
        chk("resume_step_outs", 32'(bus.outs), 32'h169);

`ifdef STEP_RATE_FAULT_EN
        bus.pul = 1'b1;
        tick(3);
        bus.pul = 1'b0;
        tick(7);
        bus.pul = 1'b1;
        tick(3);
        bus.pul = 1'b0;
        tick(20);
        chk("gap_pos", 32'(bus.pos), 32'h2);
        chk("gap_fault", 32'(bus.fault), 32'h1);
        tick(100);
        chk("gap_fault_sticky", 32'(bus.fault), 32'h1);
        rst = 1'b1;
        tick(2);
        chk("gap_fault_rst", 32'(bus.fault), 32'h0);
        chk("gap_pos_rst", 32'(bus.pos), 32'h0);
        rst = 1'b0;
`else
        chk("fault_tied_low", 32'(bus.fault), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
